// File: rtl/gouram_datatypes_pkg.sv
// Shared types and constants for the Gouram trace unit blocks.
package gouram_datatypes;

  // Trace drain sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

  // Width of the saturating dropped-record counter.
  localparam int DRAIN_CNT_W = 16;

  // Number of output words needed to carry one record.
  function automatic int words_per_rec(input int rec_w, input int word_w);
    return (rec_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/trace_drain_ctrl_fifo.sv
// Synchronous record FIFO. Exposes the head record and the one behind it so
// the drain sequencer can roll straight onto the next record without a bubble.
module trace_fifo #(
  parameter int RECORD_WIDTH = 96,
  parameter int FIFO_DEPTH   = 8,
  parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [RECORD_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic [RECORD_WIDTH-1:0] head_data,
  output logic [RECORD_WIDTH-1:0] next_data,
  output logic [LVL_W-1:0]        level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][RECORD_WIDTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  // Full/empty protection: illegal push or pop is a no-op.
  assign push_ok = push && (level != LVL_MAX);
  assign pop_ok  = pop  && (level != '0);

  assign head_data = mem[rd_ptr];
  assign next_data = mem[rd_ptr + PTR_ONE];

  // Pointers wrap naturally at FIFO_DEPTH; level tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; reset discards contents by clearing the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/trace_drain_ctrl.sv
// Buffers finished trace records and serializes them LSW-first onto a
// valid/ready word stream. The trace unit cannot be stalled, so records that
// find the FIFO full are dropped and counted instead.
module trace_drain_ctrl
  import gouram_datatypes::*;
#(
  parameter int RECORD_WIDTH = 96,
  parameter int WORD_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rec_valid,
  input  logic [RECORD_WIDTH-1:0]      rec_data,
  input  logic                         capture_enable,
  input  logic                         lock,
  output logic                         out_valid,
  output logic [WORD_WIDTH-1:0]        out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [DRAIN_CNT_W-1:0]       drop_count,
  output logic                         overflow,
  output logic                         idle
);

  localparam int WORDS_PER_REC = words_per_rec(RECORD_WIDTH, WORD_WIDTH);
  localparam int PAD_W         = WORDS_PER_REC * WORD_WIDTH;
  localparam int IDX_W         = (WORDS_PER_REC > 1) ? $clog2(WORDS_PER_REC) : 1;
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_REC - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(FIFO_DEPTH);

  typedef logic [WORDS_PER_REC-1:0][WORD_WIDTH-1:0] rec_words_t;

  logic [RECORD_WIDTH-1:0] head_data, next_data;
  rec_words_t              head_w, next_w;

  drain_state_t            state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt, idx_inc;
  logic                    valid_nxt, last_nxt;
  logic [WORD_WIDTH-1:0]   data_nxt;

  logic rec_accept, fifo_full, push, drop, hs, last_word, pop;

  // Zero-pad the records to a whole number of words, viewed as word arrays.
  assign head_w = PAD_W'(head_data);
  assign next_w = PAD_W'(next_data);

  // Gating uses the registered level, so a same-cycle pop cannot save a record.
  assign rec_accept = rec_valid && capture_enable && !lock;
  assign fifo_full  = (fifo_level == LVL_MAX);
  assign push       = rec_accept && !fifo_full;
  assign drop       = rec_accept && fifo_full;

  assign hs        = out_valid && out_ready;
  assign last_word = (idx == LAST_IDX);
  assign pop       = hs && last_word;
  assign idx_inc   = idx + IDX_W'(1);

  assign idle = (fifo_level == '0) && (state == IDLE);

  trace_fifo #(
    .RECORD_WIDTH (RECORD_WIDTH),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .LVL_W        (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rec_data),
    .pop       (pop),
    .head_data (head_data),
    .next_data (next_data),
    .level     (fifo_level)
  );

  // Sequencer next-state: word index advance, record roll-over and output regs.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    valid_nxt = out_valid;
    data_nxt  = out_data;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          valid_nxt = 1'b1;
          data_nxt  = head_w[0];
        end
      end
      SEND: begin
        if (hs) begin
          if (!last_word) begin
            idx_nxt  = idx_inc;
            data_nxt = head_w[idx_inc];
          end else if (fifo_level >= LVL_W'(2)) begin
            // Another record is already queued: start it next cycle, no bubble.
            idx_nxt  = '0;
            data_nxt = next_w[0];
          end else begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
    last_nxt = valid_nxt && (idx_nxt == LAST_IDX);
  end

  // Sequencer registers; outputs are registered so they hold under back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_last  <= last_nxt;
    end
  end

  // Dropped-record accounting: saturating count plus sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DRAIN_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trace_drain_ctrl.sv
// Directed bench for trace_drain_ctrl with a word scoreboard.
module tb_trace_drain_ctrl;

  localparam int RW = 96;
  localparam int WW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rec_valid;
  logic [RW-1:0] rec_data;
  logic          capture_enable;
  logic          lock;
  logic          out_valid;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic [3:0]    fifo_level;
  logic [15:0]   drop_count;
  logic          overflow;
  logic          idle;

  int checks   = 0;
  int failures = 0;
  logic [WW:0] sbq[$];

  always #5 clk = ~clk;

  trace_drain_ctrl #(.RECORD_WIDTH(RW), .WORD_WIDTH(WW), .FIFO_DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rec_valid      (rec_valid),
    .rec_data       (rec_data),
    .capture_enable (capture_enable),
    .lock           (lock),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count),
    .overflow       (overflow),
    .idle           (idle)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {32'hC000_0000 | v, 32'hB000_0000 | v, 32'hA000_0000 | v};
  endfunction

  task automatic push_exp(input logic [RW-1:0] r);
    for (int k = 0; k < 3; k++) sbq.push_back({r[k*WW +: WW], k == 2});
  endtask

  // One clock: score any handshake at the falling edge, then step past the rising edge.
  task automatic cyc();
    logic [WW:0] e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      check("sb_pending", 128'(sbq.size() != 0), 128'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_word", 128'({out_data, out_last}), 128'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [RW-1:0] r, input bit exp_acc);
    rec_data  = r;
    rec_valid = 1'b1;
    if (exp_acc) push_exp(r);
    cyc();
    rec_valid = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((sbq.size() != 0 || !idle) && n < maxc) begin
      cyc();
      n++;
    end
    check("drain_idle", 128'(idle), 128'd1);
    check("drain_sb_empty", 128'(sbq.size()), 128'd0);
  endtask

  initial begin
    rst_n = 1'b0; rec_valid = 1'b0; rec_data = '0;
    capture_enable = 1'b1; lock = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", 128'(out_data), 128'd0);
    check("rst_out_last", 128'(out_last), 128'd0);
    check("rst_level", 128'(fifo_level), 128'd0);
    check("rst_drop", 128'(drop_count), 128'd0);
    check("rst_overflow", 128'(overflow), 128'd0);
    check("rst_idle", 128'(idle), 128'd1);
    rst_n = 1'b1;
    cyc();

    // Single record, sink always ready.
    pulse(96'h0000_0003_0000_0002_0000_0001, 1'b1);
    check("t1_level_n1", 128'(fifo_level), 128'd1);
    check("t1_valid_n1", 128'(out_valid), 128'd0);
    cyc();
    check("t1_valid_n2", 128'(out_valid), 128'd1);
    check("t1_w0", 128'({out_data, out_last}), 128'({32'd1, 1'b0}));
    cyc();
    check("t1_w1", 128'({out_data, out_last}), 128'({32'd2, 1'b0}));
    cyc();
    check("t1_w2", 128'({out_data, out_last}), 128'({32'd3, 1'b1}));
    cyc();
    check("t1_valid_end", 128'(out_valid), 128'd0);
    check("t1_idle", 128'(idle), 128'd1);

    // Back-pressure held on the first word.
    out_ready = 1'b0;
    pulse(rec(1), 1'b1);
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 128'(out_valid), 128'd1);
      check("t2_hold_data", 128'({out_data, out_last}), 128'({32'hA000_0001, 1'b0}));
      cyc();
    end
    out_ready = 1'b1;
    repeat (3) cyc();
    check("t2_done_valid", 128'(out_valid), 128'd0);
    check("t2_done_idle", 128'(idle), 128'd1);

    // Overflow: 10 records into 8 slots, then back-to-back drain.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) pulse(rec(16 + i), i < 8);
    check("t3_level", 128'(fifo_level), 128'd8);
    check("t3_drop", 128'(drop_count), 128'd2);
    check("t3_overflow", 128'(overflow), 128'd1);
    out_ready = 1'b1;
    repeat (24) cyc();
    check("t3_valid_after24", 128'(out_valid), 128'd0);
    check("t3_sb_after24", 128'(sbq.size()), 128'd0);
    check("t3_idle", 128'(idle), 128'd1);

    // Gating: locked or disabled records are ignored, not counted.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    lock = 1'b1;
    pulse(rec(40), 1'b0);
    lock = 1'b0; capture_enable = 1'b0;
    pulse(rec(41), 1'b0);
    capture_enable = 1'b1;
    cyc();
    check("t4_level", 128'(fifo_level), 128'd0);
    check("t4_drop", 128'(drop_count), 128'd0);
    check("t4_valid", 128'(out_valid), 128'd0);
    pulse(rec(50), 1'b1);
    pulse(rec(51), 1'b1);
    lock = 1'b1;
    pulse(rec(52), 1'b0);
    wait_drain(20);
    check("t4_lock_drop", 128'(drop_count), 128'd0);
    lock = 1'b0;

    // Full FIFO with a push arriving on the last-word handshake.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pulse(rec(60 + i), 1'b1);
    check("t5_full", 128'(fifo_level), 128'd8);
    out_ready = 1'b1;
    cyc();
    cyc();
    check("t5_at_last", 128'(out_last), 128'd1);
    pulse(rec(70), 1'b0);
    check("t5_drop", 128'(drop_count), 128'd1);
    check("t5_level", 128'(fifo_level), 128'd7);
    wait_drain(40);

    // Reset in the middle of a transfer, then a fresh record.
    pulse(rec(80), 1'b1);
    pulse(rec(81), 1'b1);
    cyc();
    cyc();
    check("t6_pre_rst_word", 128'({out_data, out_last}), 128'({32'hC000_0050, 1'b1}));
    rst_n = 1'b0;
    out_ready = 1'b0;
    sbq.delete();
    cyc();
    check("t6_valid", 128'(out_valid), 128'd0);
    check("t6_level", 128'(fifo_level), 128'd0);
    check("t6_drop", 128'(drop_count), 128'd0);
    check("t6_overflow", 128'(overflow), 128'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    pulse(rec(90), 1'b1);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
